mbox_cyc_resp: RTL and testbench

- Memory-side responder for EBOX memory cycle requests issued by MCL (mcl_mbox_cyc_req_h plus the VMA qualifier strobes).
- Accepts read, write, read-pause-write and read-then-write cycles and runs them against a simple single-port backing-store handshake.
- Returns read data with an MB transfer strobe, write-done strobe, busy, and error strobes to the EBOX.
- Sits between MCL/VMA and the cache/core memory model.

---
 rtl/mbox_cyc_resp.sv | 189 ++++++++++++++++++
 tb/tb_mbox_cyc_resp.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbox_cyc_resp.sv
// mbox_cyc_resp: memory-side responder for EBOX memory cycle requests.
// Accepts read, write, read-pause-write and read-then-write cycles from MCL,
// runs them against a single-port backing-store request/ack handshake and
// returns read data, completion strobes, busy and error strobes to the EBOX.
module mbox_cyc_resp #(
    parameter int ADR_WIDTH   = 23,
    parameter int DATA_WIDTH  = 36,
    parameter int MEM_WORDS   = 262144,
    parameter int MEM_TIMEOUT = 63
) (
    input  logic                  clk_mbox_h,
    input  logic                  mr_reset_l,
    input  logic                  mcl_mbox_cyc_req_h,
    input  logic                  mcl2_vma_read_l,
    input  logic                  mcl2_vma_write_l,
    input  logic                  mcl2_vma_pause_l,
    input  logic [ADR_WIDTH-1:0]  vma_h,
    input  logic [DATA_WIDTH-1:0] ar_h,
    output logic                  mbox_busy_h,
    output logic [DATA_WIDTH-1:0] mbox_mb_h,
    output logic                  mbox_mb_xfer_h,
    output logic                  mbox_wr_done_h,
    output logic                  mbox_adr_err_h,
    output logic                  mbox_nxm_h,
    output logic                  mbox_pause_hold_h,
    output logic                  mem_req_h,
    output logic                  mem_we_h,
    output logic [ADR_WIDTH-1:0]  mem_adr_h,
    output logic [DATA_WIDTH-1:0] mem_wdata_h,
    input  logic                  mem_ack_h,
    input  logic [DATA_WIDTH-1:0] mem_rdata_h
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHK,
        S_RD,
        S_RD_DONE,
        S_HOLD,
        S_WR,
        S_WR_DONE
    } state_t;

    // Highest legal word address is MEM_WORDS-1; one extra bit keeps the
    // comparison exact even when MEM_WORDS equals 2**ADR_WIDTH.
    localparam logic [ADR_WIDTH:0] ADR_LIMIT    = (ADR_WIDTH+1)'(MEM_WORDS);
    // The counter holds the number of unacknowledged cycles already spent, so
    // the final allowed cycle is the one where it equals MEM_TIMEOUT-1.
    localparam logic [7:0]         TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t                state, next_state;
    logic                  rd_q, wr_q, pause_q;
    logic [ADR_WIDTH-1:0]  adr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] mb_q;
    logic [7:0]            cnt_q;
    logic                  hold_q;
    logic                  adr_err_q;
    logic                  nxm_q;

    logic rd_req, wr_req, pause_req;
    logic accept_new, accept_wr;
    logic set_adr_err, set_nxm;
    logic in_mem_cycle, timeout_hit, adr_bad;

    assign rd_req       = mcl_mbox_cyc_req_h && !mcl2_vma_read_l;
    assign wr_req       = mcl_mbox_cyc_req_h && !mcl2_vma_write_l;
    assign pause_req    = !mcl2_vma_pause_l;
    assign in_mem_cycle = (state == S_RD) || (state == S_WR);
    assign timeout_hit  = (cnt_q == TIMEOUT_LAST);
    assign adr_bad      = ({1'b0, adr_q} >= ADR_LIMIT);

    // State register.
    always_ff @(posedge clk_mbox_h) begin
        // NOTE: sequential state uses non-blocking assignment so every register
        // updates from pre-edge values, independent of statement order.
        if (!mr_reset_l) state <= S_IDLE;
        else             state <= next_state;
    end

    // Next-state decode and per-cycle control strobes.
    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves one
        // unassigned and no latch is inferred.
        next_state  = state;
        accept_new  = 1'b0;
        accept_wr   = 1'b0;
        set_adr_err = 1'b0;
        set_nxm     = 1'b0;
        case (state)
            S_IDLE: begin
                if (rd_req || wr_req) begin
                    accept_new = 1'b1;
                    next_state = S_CHK;
                end
            end
            S_HOLD: begin
                // A read cancels the hold and restarts as a fresh cycle; a write
                // reuses the held address.
                if (rd_req) begin
                    accept_new = 1'b1;
                    next_state = S_CHK;
                end else if (wr_req) begin
                    accept_wr  = 1'b1;
                    next_state = S_WR;
                end
            end
            S_CHK: begin
                if (adr_bad) begin
                    set_adr_err = 1'b1;
                    next_state  = S_IDLE;
                end else begin
                    next_state = rd_q ? S_RD : S_WR;
                end
            end
            S_RD, S_WR: begin
                if (mem_ack_h) begin
                    next_state = (state == S_RD) ? S_RD_DONE : S_WR_DONE;
                end else if (timeout_hit) begin
                    set_nxm    = 1'b1;
                    next_state = S_IDLE;
                end
            end
            S_RD_DONE: begin
                if (pause_q)   next_state = S_HOLD;
                else if (wr_q) next_state = S_WR;
                else           next_state = S_IDLE;
            end
            S_WR_DONE: next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    // Cycle latches, read data register, timeout counter, hold flag and
    // the registered error strobes.
    always_ff @(posedge clk_mbox_h) begin
        if (!mr_reset_l) begin
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            pause_q   <= 1'b0;
            adr_q     <= '0;
            data_q    <= '0;
            mb_q      <= '0;
            cnt_q     <= '0;
            hold_q    <= 1'b0;
            adr_err_q <= 1'b0;
            nxm_q     <= 1'b0;
        end else begin
            if (accept_new) begin
                rd_q    <= rd_req;
                wr_q    <= wr_req;
                pause_q <= pause_req;
                adr_q   <= vma_h;
                data_q  <= ar_h;
            end else if (accept_wr) begin
                rd_q    <= 1'b0;
                wr_q    <= 1'b1;
                pause_q <= 1'b0;
                data_q  <= ar_h;
            end

            if (state == S_RD && mem_ack_h) mb_q <= mem_rdata_h;

            // Counts unacknowledged request cycles; any other cycle clears it,
            // so every RD/WR entry starts from zero.
            if (in_mem_cycle && !mem_ack_h) cnt_q <= cnt_q + 8'd1;
            else                            cnt_q <= '0;

            if (accept_new || set_nxm || state == S_WR_DONE) hold_q <= 1'b0;
            else if (state == S_RD_DONE && pause_q)           hold_q <= 1'b1;

            adr_err_q <= set_adr_err;
            nxm_q     <= set_nxm;
        end
    end

    assign mbox_busy_h       = (state != S_IDLE) && (state != S_HOLD);
    assign mbox_mb_h         = mb_q;
    assign mbox_mb_xfer_h    = (state == S_RD_DONE);
    assign mbox_wr_done_h    = (state == S_WR_DONE);
    assign mbox_adr_err_h    = adr_err_q;
    assign mbox_nxm_h        = nxm_q;
    assign mbox_pause_hold_h = hold_q;
    assign mem_req_h         = in_mem_cycle;
    assign mem_we_h          = (state == S_WR);
    assign mem_adr_h         = adr_q;
    assign mem_wdata_h       = data_q;

endmodule

// File: tb/tb_mbox_cyc_resp.sv
// Testbench for mbox_cyc_resp: directed scenarios plus randomized cycles,
// each compared against a transaction-level model of the responder.
module tb_mbox_cyc_resp;

    localparam int AW = 23;
    localparam int DW = 36;
    localparam int MW = 262144;
    localparam int TO = 63;
    localparam int NO_ACK = 1000;

    logic          clk = 1'b0;
    logic          rst_l;
    logic          req, rd_l, wr_l, pause_l;
    logic [AW-1:0] vma;
    logic [DW-1:0] ar;
    logic          busy, xfer, wr_done, adr_err, nxm, hold;
    logic [DW-1:0] mb;
    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    mbox_cyc_resp dut (
        .clk_mbox_h        (clk),
        .mr_reset_l        (rst_l),
        .mcl_mbox_cyc_req_h(req),
        .mcl2_vma_read_l   (rd_l),
        .mcl2_vma_write_l  (wr_l),
        .mcl2_vma_pause_l  (pause_l),
        .vma_h             (vma),
        .ar_h              (ar),
        .mbox_busy_h       (busy),
        .mbox_mb_h         (mb),
        .mbox_mb_xfer_h    (xfer),
        .mbox_wr_done_h    (wr_done),
        .mbox_adr_err_h    (adr_err),
        .mbox_nxm_h        (nxm),
        .mbox_pause_hold_h (hold),
        .mem_req_h         (mem_req),
        .mem_we_h          (mem_we),
        .mem_adr_h         (mem_adr),
        .mem_wdata_h       (mem_wdata),
        .mem_ack_h         (mem_ack),
        .mem_rdata_h       (mem_rdata)
    );

    always #5 clk = ~clk;

    // Everything one EBOX cycle produces, as seen at the bus level.
    typedef struct packed {
        logic [1:0]    n_acc;
        logic [AW-1:0] adr0;
        logic          we0;
        logic [DW-1:0] wd0;
        logic [7:0]    cyc0;
        logic [AW-1:0] adr1;
        logic          we1;
        logic [DW-1:0] wd1;
        logic [7:0]    cyc1;
        logic [3:0]    n_xfer;
        logic [DW-1:0] mb;
        logic [3:0]    n_wrd;
        logic [3:0]    n_aerr;
        logic [3:0]    n_nxm;
        logic          hold_end;
        logic [3:0]    n_clash;
    } obs_t;

    int tests_run = 0;
    int tests_failed = 0;
    int xfer_at, first_req_at;

    // bmem is the backing store seen by the DUT; mmem is the model's view.
    logic [DW-1:0] bmem [logic [AW-1:0]];
    logic [DW-1:0] mmem [logic [AW-1:0]];

    function automatic logic [DW-1:0] fill(input logic [AW-1:0] a);
        return {13'h0A5C, a} ^ 36'h555555555;
    endfunction

    function automatic logic [DW-1:0] bread(input logic [AW-1:0] a);
        return bmem.exists(a) ? bmem[a] : fill(a);
    endfunction

    function automatic logic [DW-1:0] mread(input logic [AW-1:0] a);
        return mmem.exists(a) ? mmem[a] : fill(a);
    endfunction

    // Expected outcome of one cycle. The memory takes delay wait cycles before
    // acking; a delay that would exceed the timeout means no ack at all.
    function automatic obs_t predict(input logic rdf, input logic wrf, input logic pf,
                                     input logic hold_wr, input logic [AW-1:0] a,
                                     input logic [DW-1:0] d, input int delay);
        obs_t e;
        logic tmo;
        logic [7:0] cyc;
        e   = '0;
        tmo = (delay + 1 > TO);
        cyc = tmo ? 8'(TO) : 8'(delay + 1);
        if (hold_wr || (!rdf && wrf && int'(a) < MW)) begin
            e.n_acc = 2'd1; e.adr0 = a; e.we0 = 1'b1; e.wd0 = d; e.cyc0 = cyc;
            if (tmo) e.n_nxm = 4'd1;
            else begin e.n_wrd = 4'd1; mmem[a] = d; end
            return e;
        end
        if (int'(a) >= MW) begin
            e.n_aerr = 4'd1;
            return e;
        end
        e.n_acc = 2'd1; e.adr0 = a; e.cyc0 = cyc;
        if (tmo) begin e.n_nxm = 4'd1; return e; end
        e.n_xfer = 4'd1;
        e.mb     = mread(a);
        if (pf) begin e.hold_end = 1'b1; return e; end
        if (wrf) begin
            e.n_acc = 2'd2; e.adr1 = a; e.we1 = 1'b1; e.wd1 = d; e.cyc1 = cyc;
            if (tmo) e.n_nxm = 4'd1;
            else begin e.n_wrd = 4'd1; mmem[a] = d; end
        end
        return e;
    endfunction

    task automatic send(input logic rdf, input logic wrf, input logic pf,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
        req = 1'b1; rd_l = !rdf; wr_l = !wrf; pause_l = !pf; vma = a; ar = d;
    endtask

    // Drop the request, act as backing store and requester until the cycle
    // ends (busy seen and then released). With noise set, a changing request
    // is presented while busy; it must be ignored.
    task automatic observe(input int delay, input logic noise, output obs_t o);
        int   idx = 0, acc_cyc = 0, cur = 0;
        logic prev_req = 1'b0, seen_busy = 1'b0, done = 1'b0;
        o = '0; xfer_at = 0; first_req_at = 0;
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clk);
            idx++;
            mem_ack = 1'b0;
            if (int'(xfer) + int'(wr_done) + int'(adr_err) + int'(nxm) > 1) o.n_clash++;
            if (xfer) begin o.n_xfer++; o.mb = mb; if (xfer_at == 0) xfer_at = idx; end
            if (wr_done) o.n_wrd++;
            if (adr_err) o.n_aerr++;
            if (nxm)     o.n_nxm++;
            if (mem_req && !prev_req) begin
                cur = int'(o.n_acc);
                if (o.n_acc != 2'd3) o.n_acc = o.n_acc + 2'd1;
                acc_cyc = 0;
                if (first_req_at == 0) first_req_at = idx;
                if (cur == 0) begin
                    o.adr0 = mem_adr; o.we0 = mem_we; o.wd0 = mem_we ? mem_wdata : '0;
                end else if (cur == 1) begin
                    o.adr1 = mem_adr; o.we1 = mem_we; o.wd1 = mem_we ? mem_wdata : '0;
                end
            end
            if (mem_req) begin
                acc_cyc++;
                if (cur == 0)      o.cyc0 = 8'(acc_cyc);
                else if (cur == 1) o.cyc1 = 8'(acc_cyc);
                if (acc_cyc == delay + 1) begin
                    mem_ack   = 1'b1;
                    mem_rdata = bread(mem_adr);
                    if (mem_we) bmem[mem_adr] = mem_wdata;
                end
            end
            prev_req = mem_req;
            if (busy) seen_busy = 1'b1;
            if (noise && busy) begin
                req = 1'b1; rd_l = 1'($urandom); wr_l = 1'($urandom);
                pause_l = 1'($urandom); vma = 23'($urandom); ar = 36'({$urandom(), $urandom()});
            end else begin
                req = 1'b0;
            end
            if (seen_busy && !busy) begin
                o.hold_end = hold;
                done = 1'b1;
            end
        end
        if (!done) begin
            tests_run++; tests_failed++;
            $display("FAIL cycle_end: busy=%b seen_busy=%b after 400 cycles, required busy to rise then fall",
                     busy, seen_busy);
        end
    endtask

    task automatic test_reset();
        rst_l = 1'b0; req = 1'b1; rd_l = 1'b0; wr_l = 1'b0; pause_l = 1'b0;
        vma = 23'h12345; ar = 36'hABCDE1234; mem_ack = 1'b1; mem_rdata = 36'hFFFFFFFFF;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({busy, xfer, wr_done, adr_err, nxm, hold, mem_req, mem_we} !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b required 00000000",
                     {busy, xfer, wr_done, adr_err, nxm, hold, mem_req, mem_we});
        end
        tests_run++;
        if ({mb, mem_adr, mem_wdata} !== '0) begin
            tests_failed++;
            $display("FAIL reset_data: mb=%h adr=%h wdata=%h required all 0", mb, mem_adr, mem_wdata);
        end
        req = 1'b0; rd_l = 1'b1; wr_l = 1'b1; pause_l = 1'b1; mem_ack = 1'b0;
        rst_l = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read();
        obs_t o, e;
        bmem[23'o1000] = 36'o123456701234;
        mmem[23'o1000] = 36'o123456701234;
        e = predict(1, 0, 0, 0, 23'o1000, '0, 1);
        send(1, 0, 0, 23'o1000, '0);
        observe(1, 0, o);
        tests_run++;
        if (o !== e) begin tests_failed++; $display("FAIL read: got %h required %h", o, e); end
        tests_run++;
        if (o.mb !== 36'o123456701234 || o.cyc0 !== 8'd2 || o.we0 !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_data: mb=%o cyc=%0d we=%b required mb=123456701234 cyc=2 we=0",
                     o.mb, o.cyc0, o.we0);
        end
        tests_run++;
        if (first_req_at != 2 || xfer_at != 4) begin
            tests_failed++;
            $display("FAIL read_latency: req_at=%0d xfer_at=%0d required 2 and 4", first_req_at, xfer_at);
        end
    endtask

    task automatic test_min_latency();
        obs_t o, e;
        logic [AW-1:0] a = 23'($urandom_range(0, MW - 1));
        e = predict(1, 0, 0, 0, a, '0, 0);
        send(1, 0, 0, a, '0);
        observe(0, 0, o);
        tests_run++;
        if (o !== e) begin tests_failed++; $display("FAIL min_read: got %h required %h", o, e); end
        tests_run++;
        if (xfer_at != 3) begin
            tests_failed++;
            $display("FAIL min_latency: request to xfer %0d cycles, required 3", xfer_at);
        end
    endtask

    task automatic test_pause_write();
        obs_t o, e;
        logic held_ok = 1'b1;
        e = predict(1, 0, 1, 0, 23'o2000, 36'o777, 0);
        send(1, 0, 1, 23'o2000, 36'o777);
        observe(0, 0, o);
        tests_run++;
        if (o !== e) begin tests_failed++; $display("FAIL pause_read: got %h required %h", o, e); end
        repeat (3) begin
            @(negedge clk);
            if (hold !== 1'b1 || busy !== 1'b0 || mem_req !== 1'b0) held_ok = 1'b0;
        end
        tests_run++;
        if (!held_ok) begin
            tests_failed++;
            $display("FAIL pause_hold: hold=%b busy=%b req=%b required 1 0 0", hold, busy, mem_req);
        end
        e = predict(0, 1, 0, 1, 23'o2000, 36'o5, 2);
        send(0, 1, 0, 23'o7777, 36'o5);
        observe(2, 0, o);
        tests_run++;
        if (o !== e) begin tests_failed++; $display("FAIL pause_write: got %h required %h", o, e); end
        tests_run++;
        if (o.adr0 !== 23'o2000 || o.wd0 !== 36'o5 || hold !== 1'b0) begin
            tests_failed++;
            $display("FAIL pause_target: adr=%o data=%o hold=%b required 2000 5 0", o.adr0, o.wd0, hold);
        end
    endtask

    task automatic test_adr_err();
        obs_t o, e;
        logic [AW-1:0] pat [3];
        pat[0] = 23'(MW); pat[1] = '1; pat[2] = 23'(MW - 1);
        for (int i = 0; i < 3; i++) begin
            e = predict(1, i == 1, 0, 0, pat[i], 36'h123, 1);
            send(1, i == 1, 0, pat[i], 36'h123);
            observe(1, 0, o);
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL adr_bound%0d: adr=%h got %h required %h", i, pat[i], o, e);
            end
        end
    endtask

    task automatic test_timeout();
        obs_t o, e;
        logic [DW-1:0] d = 36'({$urandom(), $urandom()});
        logic [DW-1:0] mb_before;
        e = predict(0, 1, 0, 0, 23'o3000, d, NO_ACK);
        send(0, 1, 0, 23'o3000, d);
        observe(NO_ACK, 0, o);
        tests_run++;
        if (o !== e || mem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout: got %h req=%b required %h req=0", o, mem_req, e);
        end
        mb_before = mb;
        mem_ack = 1'b1; mem_rdata = ~mb_before;
        @(negedge clk);
        mem_ack = 1'b0;
        tests_run++;
        if ({busy, xfer, wr_done, adr_err, nxm, mem_req} !== 6'b0 || mb !== mb_before) begin
            tests_failed++;
            $display("FAIL late_ack: flags=%b mb=%h required 000000 mb=%h",
                     {busy, xfer, wr_done, adr_err, nxm, mem_req}, mb, mb_before);
        end
    endtask

    task automatic test_read_then_write();
        obs_t o, e;
        logic [DW-1:0] d = 36'({$urandom(), $urandom()});
        int dl = int'($urandom_range(0, 3));
        e = predict(1, 1, 0, 0, 23'o40, d, dl);
        send(1, 1, 0, 23'o40, d);
        observe(dl, 1, o);
        tests_run++;
        if (o !== e) begin tests_failed++; $display("FAIL read_then_write: got %h required %h", o, e); end
        tests_run++;
        if (o.n_acc !== 2'd2 || o.we1 !== 1'b1 || o.wd1 !== d || o.adr1 !== 23'o40) begin
            tests_failed++;
            $display("FAIL rtw_write: n=%0d we=%b data=%h adr=%o required 2 1 %h 40",
                     o.n_acc, o.we1, o.wd1, o.adr1, d);
        end
    endtask

    task automatic test_reset_mid_rd();
        obs_t o, e;
        logic [AW-1:0] a = 23'($urandom_range(0, MW - 1));
        int waited = 0;
        send(1, 0, 0, a, '0);
        @(negedge clk);
        req = 1'b0;
        while (!mem_req && waited < 10) begin @(negedge clk); waited++; end
        rst_l = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({busy, xfer, wr_done, adr_err, nxm, hold, mem_req, mem_we} !== 8'h00 ||
            {mb, mem_adr, mem_wdata} !== '0 || waited >= 10) begin
            tests_failed++;
            $display("FAIL reset_mid_rd: flags=%b adr=%h waited=%0d required all 0",
                     {busy, xfer, wr_done, adr_err, nxm, hold, mem_req, mem_we}, mem_adr, waited);
        end
        rst_l = 1'b1; mem_ack = 1'b1; mem_rdata = 36'h3C3C3C3C3;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        tests_run++;
        if (xfer !== 1'b0 || busy !== 1'b0 || mb !== '0) begin
            tests_failed++;
            $display("FAIL ack_in_idle: xfer=%b busy=%b mb=%h required 0 0 0", xfer, busy, mb);
        end
        e = predict(1, 0, 0, 0, a, '0, 2);
        send(1, 0, 0, a, '0);
        observe(2, 0, o);
        tests_run++;
        if (o !== e) begin tests_failed++; $display("FAIL read_after_reset: got %h required %h", o, e); end
    endtask

    task automatic test_noop();
        logic quiet = 1'b1;
        send(0, 0, 1, 23'o100, '0);
        repeat (3) begin
            @(negedge clk);
            req = 1'b0;
            if ({busy, xfer, wr_done, adr_err, nxm, hold, mem_req} !== 7'b0) quiet = 1'b0;
        end
        tests_run++;
        if (!quiet) begin
            tests_failed++;
            $display("FAIL noop: flags=%b required 0000000", {busy, xfer, wr_done, adr_err, nxm, hold, mem_req});
        end
    endtask

    task automatic test_random();
        obs_t o, e;
        logic in_hold = 1'b0;
        logic [AW-1:0] hold_adr = '0;
        logic [AW-1:0] pool [8];
        for (int i = 0; i < 8; i++) pool[i] = 23'($urandom_range(0, MW - 1));
        for (int i = 0; i < 40; i++) begin
            logic rdf, wrf, pf, hw;
            logic [AW-1:0] a, va;
            logic [DW-1:0] d = 36'({$urandom(), $urandom()});
            int dl = ($urandom_range(0, 9) == 0) ? NO_ACK : int'($urandom_range(0, 4));
            int kind = int'($urandom_range(0, 7));
            if (kind == 0)      a = 23'(MW + int'($urandom_range(0, (1 << AW) - 1 - MW)));
            else if (kind < 4)  a = pool[$urandom_range(0, 7)];
            else                a = 23'($urandom_range(0, MW - 1));
            hw = in_hold && ($urandom_range(0, 9) < 7);
            if (hw) begin
                rdf = 1'b0; wrf = 1'b1; pf = 1'b0;
                va = 23'($urandom);
                e = predict(0, 1, 0, 1, hold_adr, d, dl);
            end else begin
                rdf = in_hold ? 1'b1 : 1'($urandom);
                wrf = rdf ? 1'($urandom) : 1'b1;
                pf  = 1'($urandom);
                va  = a;
                e = predict(rdf, wrf, pf, 0, a, d, dl);
            end
            send(rdf, wrf, pf, va, d);
            observe(dl, 1'($urandom), o);
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL rand%0d rd=%b wr=%b p=%b hw=%b adr=%h dly=%0d: got %h required %h",
                         i, rdf, wrf, pf, hw, va, dl, o, e);
            end
            in_hold  = e.hold_end;
            hold_adr = a;
        end
        if (in_hold) begin
            e = predict(0, 1, 0, 1, hold_adr, 36'h1, 0);
            send(0, 1, 0, '0, 36'h1);
            observe(0, 0, o);
            tests_run++;
            if (o !== e) begin tests_failed++; $display("FAIL rand_release: got %h required %h", o, e); end
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_min_latency();
        test_pause_write();
        test_adr_err();
        test_timeout();
        test_read_then_write();
        test_reset_mid_rd();
        test_noop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
